// File: rtl/preg_pkg.sv
// Physical-register naming shared by rename, ROB, retire and the free list.
package preg_pkg;
  localparam int NUM_PREG = 64;
  localparam int NUM_AREG = 32;
  localparam int PREG_W   = $clog2(NUM_PREG);
  localparam int FL_DEPTH = NUM_PREG - NUM_AREG;
  localparam int FL_IDX_W = $clog2(FL_DEPTH);
  localparam int PREG_X0  = 0;

  typedef logic [PREG_W-1:0] preg_t;

  // p0 backs x0 and must never enter the free list
  function automatic logic is_x0(input preg_t p);
    return p == preg_t'(PREG_X0);
  endfunction
endpackage

// File: rtl/preg_free_bitmap.sv
// Double-free checker: tracks which physical registers sit in the free list
// and rejects a release of a register that is already free.
module preg_free_bitmap
  import preg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pop,
  input  logic [PREG_W-1:0] pop_preg,
  input  logic              rel_chk,
  input  logic [PREG_W-1:0] rel_preg,
  output logic              reject,
  output logic              err_double_free
);

  logic [NUM_PREG-1:0] is_free;

  // A release racing the pop of the same register is legal: it is leaving
  // the list on this edge, so re-entering it is not a duplicate.
  always_comb begin
    reject = rel_chk & is_free[rel_preg] & ~(pop & (pop_preg == rel_preg));
  end

  // Bitmap tracks list membership; set on push wins over clear on pop
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREG; i++)
        is_free[i] <= (i >= NUM_AREG);
      err_double_free <= 1'b0;
    end else begin
      if (pop)
        is_free[pop_preg] <= 1'b0;
      if (rel_chk & ~reject)
        is_free[rel_preg] <= 1'b1;
      err_double_free <= reject;
    end
  end

endmodule

// File: rtl/preg_free_list.sv
// Physical-register free list: 32-entry circular FIFO of free pregs,
// popped by rename (first-word fall-through) and refilled by retire.
// Optional double-free checker enabled by defining PREG_FREE_CHECK_EN.
module preg_free_list
  import preg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  output logic              alloc_valid,
  output logic [PREG_W-1:0] alloc_preg,
  output logic              stall,
  input  logic              rel_valid,
  input  logic [PREG_W-1:0] rel_preg,
  output logic              rel_ready,
  output logic [PREG_W-1:0] free_count,
  output logic              err_double_free
);

  logic [FL_DEPTH-1:0][PREG_W-1:0] mem;
  logic [FL_IDX_W:0]               head, tail;
  logic                            empty, pop, rel_fire, drop, reject, push;

  // Handshake decode; rel_ready comes only from registered state so a
  // same-cycle pop can never open the retire port.
  always_comb begin
    empty       = (head == tail);
    alloc_valid = ~empty;
    alloc_preg  = mem[head[FL_IDX_W-1:0]];
    stall       = alloc_req & ~alloc_valid;
    rel_ready   = free_count < PREG_W'(FL_DEPTH);
    pop         = alloc_req & alloc_valid;
    rel_fire    = rel_valid & rel_ready;
    drop        = is_x0(rel_preg);
    push        = rel_fire & ~drop & ~reject;
  end

`ifdef PREG_FREE_CHECK_EN
  preg_free_bitmap u_bitmap (
    .clk             (clk),
    .rst             (rst),
    .pop             (pop),
    .pop_preg        (alloc_preg),
    .rel_chk         (rel_fire & ~drop),
    .rel_preg        (rel_preg),
    .reject          (reject),
    .err_double_free (err_double_free)
  );
`else
  assign reject          = 1'b0;
  assign err_double_free = 1'b0;
`endif

  // FIFO storage and pointers; reset loads p32..p63 and marks the list full
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++)
        mem[i] <= PREG_W'(NUM_AREG + i);
      head       <= '0;
      tail       <= {1'b1, {FL_IDX_W{1'b0}}};
      free_count <= PREG_W'(FL_DEPTH);
    end else begin
      if (push)
        mem[tail[FL_IDX_W-1:0]] <= rel_preg;
      if (pop)
        head <= head + 1'b1;
      if (push)
        tail <= tail + 1'b1;
      free_count <= free_count + PREG_W'(push) - PREG_W'(pop);
    end
  end

endmodule

// File: tb/tb_preg_free_list.sv
// Directed, table-driven bench for preg_free_list.
module tb_preg_free_list;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_req, rel_valid;
  logic [5:0] rel_preg;
  logic       alloc_valid, stall, rel_ready, err_double_free;
  logic [5:0] alloc_preg, free_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  preg_free_list dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_req       (alloc_req),
    .alloc_valid     (alloc_valid),
    .alloc_preg      (alloc_preg),
    .stall           (stall),
    .rel_valid       (rel_valid),
    .rel_preg        (rel_preg),
    .rel_ready       (rel_ready),
    .free_count      (free_count),
    .err_double_free (err_double_free)
  );

  typedef struct {
    logic       ar, rv;
    logic [5:0] rp;
    logic       ev;
    logic [5:0] ep;
    logic       es, er;
    logic [5:0] ec;
    logic       ee;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic ar, input logic rv, input int rp,
                              input logic ev, input int ep, input logic es,
                              input logic er, input int ec, input logic ee);
    vec_t v;
    v.ar = ar; v.rv = rv; v.rp = 6'(rp);
    v.ev = ev; v.ep = 6'(ep); v.es = es; v.er = er; v.ec = 6'(ec); v.ee = ee;
    return v;
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // drive one cycle of inputs, check outputs mid-cycle, then take the edge
  task automatic step(input vec_t v, input string nm);
    alloc_req = v.ar; rel_valid = v.rv; rel_preg = v.rp;
    #1;
    cmp({nm, ".alloc_valid"}, int'(alloc_valid), int'(v.ev));
    if (v.ev) cmp({nm, ".alloc_preg"}, int'(alloc_preg), int'(v.ep));
    cmp({nm, ".stall"}, int'(stall), int'(v.es));
    cmp({nm, ".rel_ready"}, int'(rel_ready), int'(v.er));
    cmp({nm, ".free_count"}, int'(free_count), int'(v.ec));
    cmp({nm, ".err"}, int'(err_double_free), int'(v.ee));
    @(posedge clk); #1;
  endtask

  // reset with a pop and push pending to show reset overrides them
  task automatic do_reset();
    rst = 1'b1; alloc_req = 1'b1; rel_valid = 1'b1; rel_preg = 6'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; alloc_req = 1'b0; rel_valid = 1'b0; rel_preg = 6'd0;
  endtask

  initial begin
    // drain, stall, release-on-empty, p0 drops
    for (int i = 0; i < 32; i++)
      tbl.push_back(mk(1, 0, 0, 1, 32 + i, 0, i != 0, 32 - i, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0));   // 33rd request stalls
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0));   // no pointer change
    tbl.push_back(mk(1, 1, 5, 0, 0, 1, 1, 0, 0));   // p5 freed, no bypass
    tbl.push_back(mk(1, 0, 0, 1, 5, 0, 1, 1, 0));   // p5 pops next cycle
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0));   // p0 on empty list
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0));   // p0 not returned
    tbl.push_back(mk(0, 1, 9, 0, 0, 0, 1, 0, 0));   // push p9
    tbl.push_back(mk(0, 1, 0, 1, 9, 0, 1, 1, 0));   // p0 on non-empty list
    tbl.push_back(mk(1, 0, 0, 1, 9, 0, 1, 1, 0));   // count unchanged
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0));   // empty again

    alloc_req = 1'b0; rel_valid = 1'b0; rel_preg = 6'd0;
    do_reset();
    step(mk(0, 0, 0, 1, 32, 0, 0, 32, 0), "reset");
    foreach (tbl[i]) step(tbl[i], $sformatf("tbl%0d", i));

    // steady-state alloc+release of p7 across pointer wrap
    do_reset();
    for (int k = 0; k < 4; k++)
      step(mk(1, 0, 0, 1, 32 + k, 0, k != 0, 32 - k, 0), $sformatf("pre%0d", k));
    for (int k = 0; k < 40; k++) begin
      int ec;
      logic ee;
`ifdef PREG_FREE_CHECK_EN
      ec = (k == 0) ? 28 : ((k <= 28) ? 29 - k : 1);
      ee = (k >= 2 && k <= 28);
`else
      ec = 28;
      ee = 1'b0;
`endif
      step(mk(1, 1, 7, 1, (k < 28) ? 36 + k : 7, 0, 1, ec, ee), $sformatf("wrap%0d", k));
    end
`ifdef PREG_FREE_CHECK_EN
    step(mk(0, 0, 0, 1, 7, 0, 1, 1, 0), "wrap_end");
`else
    step(mk(0, 0, 0, 1, 7, 0, 1, 28, 0), "wrap_end");
`endif

    // full list holds off retire; pop opens it only on the next cycle
    do_reset();
    step(mk(0, 1, 10, 1, 32, 0, 0, 32, 0), "full0");
    step(mk(1, 1, 10, 1, 32, 0, 0, 32, 0), "full1");
    step(mk(0, 1, 10, 1, 33, 0, 1, 31, 0), "full2");
    step(mk(0, 0, 0, 1, 33, 0, 0, 32, 0), "full3");
    for (int j = 0; j < 31; j++)
      step(mk(1, 0, 0, 1, 33 + j, 0, j != 0, 32 - j, 0), $sformatf("fdrain%0d", j));
    step(mk(1, 0, 0, 1, 10, 0, 1, 1, 0), "p10_out");
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), "fempty");

    // release of a register that is still free
    do_reset();
    step(mk(1, 0, 0, 1, 32, 0, 0, 32, 0), "df0");
    step(mk(0, 1, 40, 1, 33, 0, 1, 31, 0), "df1");
`ifdef PREG_FREE_CHECK_EN
    step(mk(0, 0, 0, 1, 33, 0, 1, 31, 1), "df2");
    step(mk(0, 0, 0, 1, 33, 0, 1, 31, 0), "df3");
`else
    step(mk(0, 0, 0, 1, 33, 0, 0, 32, 0), "df2");
    step(mk(0, 0, 0, 1, 33, 0, 0, 32, 0), "df3");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/preg_free_list.md
# preg_free_list

Physical-register free list for the rename/retire pair. Rename pops one free physical register per cycle for each destination it renames. Retire pushes back the superseded mapping (`old_dr`) when the overwriting instruction commits. The block is a 32-entry circular FIFO, initialised to p32–p63, and sits between the rename stage and the ROB retire port.

## Interface
- `NUM_PREG`, 64, total physical registers
- `NUM_AREG`, 32, architectural registers, permanently mapped
- `PREG_W`, 6, physical register index width
- `FL_DEPTH`, `NUM_PREG-NUM_AREG` (32), free list capacity
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `alloc_req`  in  1  rename requests one physical register this cycle
- `alloc_valid`  out  1  list non-empty; `alloc_preg` is meaningful
- `alloc_preg`  out  `PREG_W`  register at head (first-word fall-through)
- `stall`  out  1  `alloc_req & ~alloc_valid`
- `rel_valid`  in  1  retire presents a register to free
- `rel_preg`  in  `PREG_W`  register being freed (committed `old_dr`)
- `rel_ready`  out  1  `free_count < FL_DEPTH`
- `free_count`  out  `PREG_W`  registered occupancy, 0..32
- `err_double_free`  out  1  one-cycle pulse, illegal release rejected (checker builds only)

## Operation
- Storage: `mem[0..31]` of `PREG_W`. Pointers `head` and `tail` are 6-bit: 5 index bits plus a wrap bit.
- Empty when the pointers are equal. Full when the index bits match and the wrap bits differ.
- Pop fires when `alloc_req & alloc_valid`: `head <= head+1`.
- Push fires when `rel_valid & rel_ready & ~drop`: `mem[tail] <= rel_preg`, `tail <= tail+1`.
- `drop` is asserted when `rel_preg == 0`. p0 is never freed: it is the x0 mapping and is never renamed. A dropped release is still consumed, counts as accepted, and is not pushed.
- Count update: `free_count <= free_count + push - pop`. Simultaneous push and pop leaves the count unchanged.
- Empty list with `alloc_req`:
  - `stall`=1, no pointer change.
  - No bypass: a same-cycle release becomes poppable next cycle.
- Full list:
  - `rel_ready`=0, and retire must hold its request.
  - A same-cycle pop does not raise `rel_ready`; there is no combinational path from `alloc_req` to `rel_ready`.
- Indices wrap modulo 32. The wrap bit toggles on each wrap.

## Timing
- Reset (`rst`=1 at an edge), state after that edge:
  - `mem[i] = 32+i`, `head=0`, `tail=6'b100000` (full)
  - `free_count=32`, `err_double_free=0`
- Outputs after reset: `alloc_valid=1`, `alloc_preg=32`, `rel_ready=0`.
- `rst` overrides any pop or push in the same cycle. In-flight releases are lost, and retire must also be reset.
- Alloc latency is 0: `alloc_preg` is combinational from `mem[head]`. The next entry appears the cycle after the pop.
- Release-to-available latency is 1 cycle, and only when the list was empty; otherwise the register sits behind older entries in FIFO order.
- `free_count` reflects the pushes and pops of the previous edge.

## Configuration
- Macro: `PREG_FREE_CHECK_EN`.
- Defined:
  - Adds a `NUM_PREG`-bit `is_free` bitmap. Reset sets bits 32..63 and clears the rest.
  - Pop clears the bit of `alloc_preg`. Push sets the bit of `rel_preg`.
  - A release whose bit is already set is rejected: no push, `rel_ready` handshake still completes.
  - A rejected release raises `err_double_free` for exactly one cycle after the edge.
  - A simultaneous pop and release of the same register is legal and leaves the bit set.
- Undefined: no bitmap, `err_double_free` tied 0, all non-p0 releases pushed.

## Structure
- Shared package `preg_pkg`: `NUM_PREG`, `NUM_AREG`, `PREG_W`, `FL_DEPTH`, `PREG_X0 = 0`, and a `preg_t` typedef. The rename stage, ROB and retire stage import it.
- One sub-module, `preg_free_bitmap`. It is instantiated only under `PREG_FREE_CHECK_EN` and owns `is_free` and the error pulse.

## Test plan
- Reset, then 32 consecutive `alloc_req` → `alloc_preg` = 32,33,…,63 one per cycle, `free_count` 32→0. The 33rd request gives `stall=1` and no pointer change.
- Empty list, release p5 with `alloc_req` held high → `stall=1` that cycle. The next cycle gives `alloc_valid=1` and `alloc_preg=5`.
- After 4 allocs, simultaneous alloc and release of p7 each cycle for 40 cycles → `free_count` constant at 28. The pointers wrap cleanly and p7 re-emerges in FIFO order.
- Release p0 with the list not full → accepted, `free_count` unchanged, p0 never returned by alloc.
- Full list, `rel_valid=1` with p10 → `rel_ready=0`. Alloc one entry; `rel_ready=1` the next cycle and p10 is pushed at `tail`.
- With `PREG_FREE_CHECK_EN`: release p40 while it is still free → `err_double_free=1` for one cycle, `free_count` unchanged. Without the macro, the same stimulus pushes p40 and `free_count` increments.
